// File: rtl/light_strobe_pkg.sv
// Shared types, default sizes and helpers for the light strobe sequencer.
package light_strobe_pkg;

  localparam int LS_NUM_CH  = 3;
  localparam int LS_CNT_W   = 24;
  localparam int LS_PAT_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ON    = 2'd2
  } ch_state_e;

  // Reference per-channel configuration layout at the default counter width.
  typedef struct packed {
    logic                en;
    logic [LS_CNT_W-1:0] delay;
    logic [LS_CNT_W-1:0] width;
    logic [LS_CNT_W-1:0] high;
  } ch_cfg_t;

  function automatic int idx_width(input int pat_len);
    return (pat_len > 1) ? $clog2(pat_len) : 1;
  endfunction

endpackage

// File: rtl/light_strobe_ch.sv
// One light channel: IDLE -> DELAY -> ON strobe FSM with PWM dimming inside the
// on-window. Timing parameters are latched at arm time so a running strobe is fixed.
module light_strobe_ch
  import light_strobe_pkg::*;
#(
  parameter int CNT_W = LS_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             evt_i,
  input  logic             fire_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] high_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             light_d_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             overrun_q, overrun_d;
  logic             pwm_on;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      width_q   <= '0;
      high_q    <= '0;
      period_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      width_q   <= width_d;
      high_q    <= high_d;
      period_q  <= period_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    width_d   = width_q;
    high_d    = high_q;
    period_d  = period_q;
    overrun_d = evt_i && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (evt_i && fire_i) begin
          width_d  = width_i;
          high_d   = high_i;
          period_d = period_i;
          if (delay_i != '0) begin
            state_d = ST_DELAY;
            cnt_d   = delay_i - ONE;
          end else if (width_i != '0) begin
            state_d = ST_ON;
            cnt_d   = width_i - ONE;
            phase_d = '0;
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (width_q != '0) begin
          state_d = ST_ON;
          cnt_d   = width_q - ONE;
          phase_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ON: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - ONE;
          phase_d = (phase_q == period_q - ONE) ? '0 : phase_q + ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A zero high time is dark even when the period is zero; otherwise period=0 or
  // high>=period means solid on for the whole window.
  assign pwm_on    = (high_d != '0) &&
                     ((period_d == '0) || (high_d >= period_d) || (phase_d < high_d));
  assign light_d_o = (state_d == ST_ON) && pwm_on;
  assign busy_o    = (state_q != ST_IDLE);
  assign overrun_o = overrun_q;

endmodule

// File: rtl/light_strobe_seq.sv
// Frame-synchronous N-channel light strobe sequencer: trigger edge detect, shadowed
// config, frame pattern index and optional LIGHT_STROBE_INTERLOCK_EN lowest-index-wins gating.
module light_strobe_seq
  import light_strobe_pkg::*;
#(
  parameter int NUM_CH  = LS_NUM_CH,
  parameter int CNT_W   = LS_CNT_W,
  parameter int PAT_LEN = LS_PAT_LEN
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst,
  input  logic                                frame_trig,
  input  logic                                cfg_update,
  input  logic [NUM_CH-1:0]                   cfg_ch_en,
  input  logic [NUM_CH*CNT_W-1:0]             cfg_delay,
  input  logic [NUM_CH*CNT_W-1:0]             cfg_width,
  input  logic [NUM_CH*CNT_W-1:0]             cfg_high,
  input  logic [CNT_W-1:0]                    cfg_period,
  input  logic [NUM_CH*PAT_LEN-1:0]           cfg_pattern,
  output logic [NUM_CH-1:0]                   light_en,
  output logic [NUM_CH-1:0]                   ch_busy,
  output logic [idx_width(PAT_LEN)-1:0]       frame_idx,
  output logic [NUM_CH-1:0]                   overrun
);

  localparam int               IDX_W    = idx_width(PAT_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef struct packed {
    logic               en;
    logic [CNT_W-1:0]   delay;
    logic [CNT_W-1:0]   width;
    logic [CNT_W-1:0]   high;
    logic [PAT_LEN-1:0] pattern;
  } ch_set_t;

  logic              trig_prev_q;
  logic              trig_armed_q;
  logic              pend_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  sh_period_q;
  logic [CNT_W-1:0]  act_period_q;
  logic [CNT_W-1:0]  eff_period;
  logic [NUM_CH-1:0] light_raw;
  logic [NUM_CH-1:0] light_gated;
  logic [NUM_CH-1:0] light_en_q;
  logic              frame_evt;

  // A trigger held high through reset must be seen low once before it can fire.
  assign frame_evt  = frame_trig & ~trig_prev_q & trig_armed_q;
  assign eff_period = pend_q ? sh_period_q : act_period_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      trig_prev_q  <= 1'b0;
      trig_armed_q <= 1'b0;
      pend_q       <= 1'b0;
      idx_q        <= '0;
      sh_period_q  <= '0;
      act_period_q <= '0;
      light_en_q   <= '0;
    end else begin
      trig_prev_q  <= frame_trig;
      trig_armed_q <= trig_armed_q | ~frame_trig;
      if (cfg_update) begin
        pend_q      <= 1'b1;
        sh_period_q <= cfg_period;
      end else if (frame_evt) begin
        pend_q <= 1'b0;
      end
      if (frame_evt) begin
        if (pend_q) begin
          act_period_q <= sh_period_q;
        end
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
      end
      light_en_q <= light_gated;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ch_set_t cfg_in;
    ch_set_t sh_q;
    ch_set_t act_q;
    ch_set_t eff;
    logic    fire;

    assign cfg_in.en      = cfg_ch_en[gi];
    assign cfg_in.delay   = cfg_delay[gi*CNT_W +: CNT_W];
    assign cfg_in.width   = cfg_width[gi*CNT_W +: CNT_W];
    assign cfg_in.high    = cfg_high[gi*CNT_W +: CNT_W];
    assign cfg_in.pattern = cfg_pattern[gi*PAT_LEN +: PAT_LEN];

    // The event that applies a pending update also arms from the new values.
    assign eff  = pend_q ? sh_q : act_q;
    assign fire = eff.en & eff.pattern[idx_q];

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        sh_q  <= '0;
        act_q <= '0;
      end else begin
        if (cfg_update) begin
          sh_q <= cfg_in;
        end
        if (frame_evt && pend_q) begin
          act_q <= sh_q;
        end
      end
    end

    light_strobe_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_i     (sys_clk),
      .rst_i     (sys_rst),
      .evt_i     (frame_evt),
      .fire_i    (fire),
      .delay_i   (eff.delay),
      .width_i   (eff.width),
      .high_i    (eff.high),
      .period_i  (eff_period),
      .light_d_o (light_raw[gi]),
      .busy_o    (ch_busy[gi]),
      .overrun_o (overrun[gi])
    );
  end

`ifdef LIGHT_STROBE_INTERLOCK_EN
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lock
    if (gi == 0) begin : g_first
      assign light_gated[gi] = light_raw[gi];
    end else begin : g_rest
      assign light_gated[gi] = light_raw[gi] & ~(|light_raw[gi-1:0]);
    end
  end
`else
  assign light_gated = light_raw;
`endif

  assign light_en  = light_en_q;
  assign frame_idx = idx_q;

endmodule
